// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one external bus port between fetch and memory stage
// Registered request/ready sequencing, one-cycle valid pulses, stall generation, watchdog abort.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IF_Req,
    input  logic [31:0] IF_Addr,
    output logic [31:0] IF_Rdata,
    output logic        IF_Valid,
    input  logic        MEM_Req,
    input  logic        MEM_W_En,
    input  logic [2:0]  MEM_Control,
    input  logic [31:0] MEM_Addr,
    input  logic [31:0] MEM_Wdata,
    output logic [31:0] MEM_Rdata,
    output logic        MEM_Valid,
    output logic        Stall_F,
    output logic        Stall_M,
    output logic        BUS_Req,
    output logic        BUS_We,
    output logic [2:0]  BUS_Size,
    output logic [31:0] BUS_Addr,
    output logic [31:0] BUS_Wdata,
    input  logic        BUS_Ready,
    input  logic [31:0] BUS_Rdata,
    output logic        BUS_Err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT_IF,
        S_GRANT_MEM,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_start_if;
    logic        w_start_mem;
    logic        w_done;
    logic        w_abort;
    logic        w_in_grant;
    logic        w_timeout_hit;

    logic        r_grant_mem;
    logic [7:0]  r_wait_cnt;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [2:0]  r_bus_size;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_mem_rdata;
    logic        r_err;

    assign w_in_grant    = (r_state == S_GRANT_IF) || (r_state == S_GRANT_MEM);
    // Hit when this wait cycle would bring the counter up to TIMEOUT.
    assign w_timeout_hit = (r_wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_if  = 1'b0;
        w_start_mem = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MEM_Req) begin
                    w_state_nxt = S_GRANT_MEM;
                    w_start_mem = 1'b1;
                end else if (IF_Req) begin
                    w_state_nxt = S_GRANT_IF;
                    w_start_if  = 1'b1;
                end
            end
            S_GRANT_IF, S_GRANT_MEM: begin
                // Completion takes priority over a coincident timeout.
                if (BUS_Ready) begin
                    w_state_nxt = S_RESP;
                    w_done      = 1'b1;
                end else if (w_timeout_hit) begin
                    w_state_nxt = S_RESP;
                    w_abort     = 1'b1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_grant_mem <= 1'b0;
            r_wait_cnt  <= 8'd0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_size  <= 3'd0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_if_rdata  <= 32'd0;
            r_mem_rdata <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            if (w_start_if) begin
                r_grant_mem <= 1'b0;
                r_wait_cnt  <= 8'd0;
                r_bus_req   <= 1'b1;
                r_bus_we    <= 1'b0;
                r_bus_size  <= 3'b010;
                r_bus_addr  <= IF_Addr;
                r_bus_wdata <= 32'd0;
            end else if (w_start_mem) begin
                r_grant_mem <= 1'b1;
                r_wait_cnt  <= 8'd0;
                r_bus_req   <= 1'b1;
                r_bus_we    <= MEM_W_En;
                r_bus_size  <= MEM_Control;
                r_bus_addr  <= MEM_Addr;
                r_bus_wdata <= MEM_Wdata;
            end
            if (w_in_grant && !BUS_Ready) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_done) begin
                r_bus_req <= 1'b0;
                if (r_grant_mem) begin
                    r_mem_rdata <= r_bus_we ? 32'd0 : BUS_Rdata;
                end else begin
                    r_if_rdata <= BUS_Rdata;
                end
            end
            if (w_abort) begin
                r_bus_req <= 1'b0;
                r_err     <= 1'b1;
                if (r_grant_mem) begin
                    r_mem_rdata <= 32'd0;
                end else begin
                    r_if_rdata <= 32'd0;
                end
            end
        end
    end

    assign IF_Valid  = (r_state == S_RESP) && !r_grant_mem;
    assign MEM_Valid = (r_state == S_RESP) && r_grant_mem;
    assign IF_Rdata  = r_if_rdata;
    assign MEM_Rdata = r_mem_rdata;
    assign Stall_F   = IF_Req && !IF_Valid;
    assign Stall_M   = MEM_Req && !MEM_Valid;
    assign BUS_Req   = r_bus_req;
    assign BUS_We    = r_bus_we;
    assign BUS_Size  = r_bus_size;
    assign BUS_Addr  = r_bus_addr;
    assign BUS_Wdata = r_bus_wdata;
    assign BUS_Err   = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IF_Req = 1'b0;
    logic [31:0] IF_Addr = 32'd0;
    logic [31:0] IF_Rdata;
    logic        IF_Valid;
    logic        MEM_Req = 1'b0;
    logic        MEM_W_En = 1'b0;
    logic [2:0]  MEM_Control = 3'd0;
    logic [31:0] MEM_Addr = 32'd0;
    logic [31:0] MEM_Wdata = 32'd0;
    logic [31:0] MEM_Rdata;
    logic        MEM_Valid;
    logic        Stall_F;
    logic        Stall_M;
    logic        BUS_Req;
    logic        BUS_We;
    logic [2:0]  BUS_Size;
    logic [31:0] BUS_Addr;
    logic [31:0] BUS_Wdata;
    logic        BUS_Ready = 1'b0;
    logic [31:0] BUS_Rdata = 32'd0;
    logic        BUS_Err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.TIMEOUT(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Rdata(IF_Rdata), .IF_Valid(IF_Valid),
        .MEM_Req(MEM_Req), .MEM_W_En(MEM_W_En), .MEM_Control(MEM_Control),
        .MEM_Addr(MEM_Addr), .MEM_Wdata(MEM_Wdata), .MEM_Rdata(MEM_Rdata), .MEM_Valid(MEM_Valid),
        .Stall_F(Stall_F), .Stall_M(Stall_M),
        .BUS_Req(BUS_Req), .BUS_We(BUS_We), .BUS_Size(BUS_Size), .BUS_Addr(BUS_Addr),
        .BUS_Wdata(BUS_Wdata), .BUS_Ready(BUS_Ready), .BUS_Rdata(BUS_Rdata), .BUS_Err(BUS_Err)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    int cnt_300;
    int cnt_valid;

    initial begin
        // Reset state
        @(negedge CLK);
        check_eq("rst_bus_req", 32'(BUS_Req), 32'd0);
        check_eq("rst_valids", {30'd0, IF_Valid, MEM_Valid}, 32'd0);
        check_eq("rst_bus_addr", BUS_Addr, 32'd0);
        check_eq("rst_err", 32'(BUS_Err), 32'd0);
        check_eq("rst_stalls", {30'd0, Stall_F, Stall_M}, 32'd0);
        tick();
        RST_N = 1'b1;
        tick();

        // 1. Single fetch
        IF_Req = 1'b1; IF_Addr = 32'h100;
        tick();
        check_eq("t1_bus_req", 32'(BUS_Req), 32'd1);
        check_eq("t1_bus_addr", BUS_Addr, 32'h100);
        check_eq("t1_bus_we", 32'(BUS_We), 32'd0);
        check_eq("t1_bus_size", 32'(BUS_Size), 32'd2);
        check_eq("t1_stall_f_wait", 32'(Stall_F), 32'd1);
        BUS_Ready = 1'b1; BUS_Rdata = 32'h00500093;
        tick();
        check_eq("t1_if_valid", 32'(IF_Valid), 32'd1);
        check_eq("t1_if_rdata", IF_Rdata, 32'h00500093);
        check_eq("t1_stall_f_resp", 32'(Stall_F), 32'd0);
        check_eq("t1_bus_req_drop", 32'(BUS_Req), 32'd0);
        IF_Req = 1'b0; BUS_Ready = 1'b0;
        tick();
        check_eq("t1_valid_gone", 32'(IF_Valid), 32'd0);

        // 2. Simultaneous requests: memory stage wins
        IF_Req = 1'b1; IF_Addr = 32'h104;
        MEM_Req = 1'b1; MEM_W_En = 1'b0; MEM_Control = 3'b010; MEM_Addr = 32'h2000;
        tick();
        check_eq("t2_mem_addr", BUS_Addr, 32'h2000);
        check_eq("t2_stalls", {30'd0, Stall_F, Stall_M}, 32'd3);
        BUS_Ready = 1'b1; BUS_Rdata = 32'hDEADBEEF;
        tick();
        check_eq("t2_valids_mem", {30'd0, IF_Valid, MEM_Valid}, 32'd1);
        check_eq("t2_mem_rdata", MEM_Rdata, 32'hDEADBEEF);
        check_eq("t2_stall_f_held", 32'(Stall_F), 32'd1);
        MEM_Req = 1'b0; BUS_Ready = 1'b0;
        tick();
        check_eq("t2_idle_gap", {29'd0, BUS_Req, IF_Valid, MEM_Valid}, 32'd0);
        tick();
        check_eq("t2_if_addr", BUS_Addr, 32'h104);
        check_eq("t2_if_req", 32'(BUS_Req), 32'd1);
        BUS_Ready = 1'b1; BUS_Rdata = 32'h11112222;
        tick();
        check_eq("t2_valids_if", {30'd0, IF_Valid, MEM_Valid}, 32'd2);
        check_eq("t2_if_rdata", IF_Rdata, 32'h11112222);
        IF_Req = 1'b0; BUS_Ready = 1'b0;
        tick();

        // 3. Store with 4 wait cycles
        MEM_Req = 1'b1; MEM_W_En = 1'b1; MEM_Control = 3'b000;
        MEM_Addr = 32'h2003; MEM_Wdata = 32'hAB;
        BUS_Rdata = 32'hFFFFFFFF;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t3_req_%0d", i), 32'(BUS_Req), 32'd1);
            check_eq($sformatf("t3_addr_%0d", i), BUS_Addr, 32'h2003);
            check_eq($sformatf("t3_wdata_%0d", i), BUS_Wdata, 32'hAB);
            check_eq($sformatf("t3_we_size_%0d", i), {28'd0, BUS_We, BUS_Size}, 32'h8);
            check_eq($sformatf("t3_novalid_%0d", i), 32'(MEM_Valid), 32'd0);
            if (i == 4) BUS_Ready = 1'b1;
            tick();
        end
        check_eq("t3_valid", 32'(MEM_Valid), 32'd1);
        check_eq("t3_rdata_zero", MEM_Rdata, 32'd0);
        check_eq("t3_req_drop", 32'(BUS_Req), 32'd0);
        MEM_Req = 1'b0; MEM_W_En = 1'b0; BUS_Ready = 1'b0;
        tick();
        check_eq("t3_single_pulse", 32'(MEM_Valid), 32'd0);

        // 4b. Ready on the 8th grant cycle completes normally
        MEM_Req = 1'b1; MEM_Addr = 32'h3000; MEM_Control = 3'b010;
        tick();
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t4b_req_%0d", i), 32'(BUS_Req), 32'd1);
            if (i == 7) begin
                BUS_Ready = 1'b1; BUS_Rdata = 32'h12345678;
            end
            tick();
        end
        check_eq("t4b_valid", 32'(MEM_Valid), 32'd1);
        check_eq("t4b_rdata", MEM_Rdata, 32'h12345678);
        check_eq("t4b_no_err", 32'(BUS_Err), 32'd0);
        MEM_Req = 1'b0; BUS_Ready = 1'b0;
        tick();

        // 4a. Hung bus aborts after 8 wait cycles
        MEM_Req = 1'b1; MEM_Addr = 32'h3004; BUS_Rdata = 32'h55;
        tick();
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t4a_req_%0d", i), 32'(BUS_Req), 32'd1);
            check_eq($sformatf("t4a_err_low_%0d", i), 32'(BUS_Err), 32'd0);
            tick();
        end
        check_eq("t4a_req_drop", 32'(BUS_Req), 32'd0);
        check_eq("t4a_valid", 32'(MEM_Valid), 32'd1);
        check_eq("t4a_rdata_zero", MEM_Rdata, 32'd0);
        check_eq("t4a_err_set", 32'(BUS_Err), 32'd1);
        MEM_Req = 1'b0;
        tick();
        tick();
        check_eq("t4a_err_sticky", 32'(BUS_Err), 32'd1);

        // 5. Asynchronous reset mid-grant
        IF_Req = 1'b1; IF_Addr = 32'h200;
        tick();
        check_eq("t5_req_before", 32'(BUS_Req), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        check_eq("t5_req_async_drop", 32'(BUS_Req), 32'd0);
        check_eq("t5_err_cleared", 32'(BUS_Err), 32'd0);
        @(negedge CLK);
        check_eq("t5_no_valid", {30'd0, IF_Valid, MEM_Valid}, 32'd0);
        RST_N = 1'b1;
        tick();
        check_eq("t5_reissue_req", 32'(BUS_Req), 32'd1);
        check_eq("t5_reissue_addr", BUS_Addr, 32'h200);
        BUS_Ready = 1'b1; BUS_Rdata = 32'hCAFE0001;
        tick();
        check_eq("t5_valid", 32'(IF_Valid), 32'd1);
        check_eq("t5_rdata", IF_Rdata, 32'hCAFE0001);
        IF_Req = 1'b0; BUS_Ready = 1'b0;
        tick();

        // 6. Held request: one transaction per address, new address after Valid
        cnt_300 = 0;
        cnt_valid = 0;
        IF_Req = 1'b1; IF_Addr = 32'h300; BUS_Ready = 1'b1; BUS_Rdata = 32'h77;
        for (int i = 0; i < 8; i++) begin
            if (BUS_Req && BUS_Addr == 32'h300) cnt_300++;
            if (IF_Valid) cnt_valid++;
            check_eq($sformatf("t6_no_mem_valid_%0d", i), 32'(MEM_Valid), 32'd0);
            if (IF_Valid && IF_Addr == 32'h300) IF_Addr = 32'h304;
            tick();
        end
        check_eq("t6_one_txn_300", 32'(cnt_300), 32'd1);
        check_eq("t6_valid_count", 32'(cnt_valid), 32'd2);
        IF_Req = 1'b0; BUS_Ready = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

endmodule
